// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one 64-bit add/sub datapath among NUM_REQ requesters
module adder_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [64*NUM_REQ-1:0]   req_a,
    input  logic [64*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_sub,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [63:0]             rsp_sum,
    output logic                    rsp_cout,
    output logic                    rsp_ovf
);
    logic               r_op_valid;
    logic [63:0]        r_op_a;
    logic [63:0]        r_op_b;
    logic               r_op_sub;
    logic [ID_W-1:0]    r_op_id;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gid;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [63:0]        w_a;
    logic [63:0]        w_b;
    logic               w_sub;
    logic               w_s2_free;
    logic               w_s1_adv;
    logic               w_s1_free;
    logic               w_xfer;
    logic [63:0]        w_b_eff;
    logic [63:0]        w_sum;
    logic               w_cout;
    logic               w_ovf;
    int                 w_j;

    // Round-robin pick: scan downward so the requester closest to r_rr_ptr is written last and wins
    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_a     = '0;
        w_b     = '0;
        w_sub   = 1'b0;
        w_j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[w_j]) begin
                w_grant      = '0;
                w_grant[w_j] = 1'b1;
                w_gid        = ID_W'(w_j);
                w_a          = req_a[64*w_j +: 64];
                w_b          = req_b[64*w_j +: 64];
                w_sub        = req_sub[w_j];
            end
        end
    end

    // Pipeline advance, handshake and the shared adder; ready is forced low while reset is held
    always_comb begin
        w_s2_free = !rsp_valid | rsp_ready;
        w_s1_adv  = r_op_valid & w_s2_free;
        w_s1_free = !r_op_valid | w_s1_adv;
        req_ready = (w_s1_free & !rst) ? w_grant : '0;
        w_xfer    = |(req_valid & req_ready);
        w_ptr_nxt = (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
        w_b_eff   = r_op_b ^ {64{r_op_sub}};
        {w_cout, w_sum} = {1'b0, r_op_a} + {1'b0, w_b_eff} + 65'(r_op_sub);
        w_ovf     = (r_op_a[63] == w_b_eff[63]) & (w_sum[63] != r_op_a[63]);
    end

    // S1 operand register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_valid <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_sub   <= 1'b0;
            r_op_id    <= '0;
            r_rr_ptr   <= '0;
        end else if (w_xfer) begin
            r_op_valid <= 1'b1;
            r_op_a     <= w_a;
            r_op_b     <= w_b;
            r_op_sub   <= w_sub;
            r_op_id    <= w_gid;
            r_rr_ptr   <= w_ptr_nxt;
        end else if (w_s1_free) begin
            r_op_valid <= 1'b0;
        end
    end

    // S2 result register, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else if (w_s1_adv) begin
            rsp_valid <= 1'b1;
            rsp_id    <= r_op_id;
            rsp_sum   <= w_sum;
            rsp_cout  <= w_cout;
            rsp_ovf   <= w_ovf;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one instance of the team's 64-bit prefix adder/subtractor (adder_64b) between NUM_REQ requesters.
- Arbitrates among requesters round-robin and registers the winning operands.
- Drives the shared adder from those registered operands and returns a registered, tagged result through a valid/ready response port.
- Sits between the ALU-side execution units and the single shared adder.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of rsp_id; must equal clog2(NUM_REQ)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit set
req_a  input  64*NUM_REQ  operand a; slice i is bits [64i+63:64i]
req_b  input  64*NUM_REQ  operand b, same packing
req_sub  input  NUM_REQ  1 = a-b, 0 = a+b
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  ID_W  index of the requester that owns the result
rsp_sum  output  64  adder sum
rsp_cout  output  1  adder carry-out (for subtract: 1 means no borrow)
rsp_ovf  output  1  signed overflow

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. On rst, all flops clear immediately:
  - op_valid=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, rr_ptr=0.
  - req_ready is combinational and is therefore all-zero while rst is held.
- Pipeline: two register stages.
  - S1 (operand reg): op_valid, op_a, op_b, op_sub, op_id.
  - S2 (result reg): rsp_*.
  - The adder is combinational between S1 and S2. Inputs are a=op_a, b=op_b, s=op_sub.
- Advance conditions:
  - s2_free = !rsp_valid | rsp_ready.
  - s1_adv = op_valid & s2_free.
  - s1_free = !op_valid | s1_adv.
- Arbitration:
  - grant = first set bit of req_valid, searching from index rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[i] = s1_free & grant[i].
  - req_ready is combinational and may depend on the same-cycle req_valid.
- Handshake:
  - A request transfers on a cycle with req_valid[i] & req_ready[i].
  - On transfer, S1 loads slice i, op_id=i, op_valid=1, and rr_ptr = (i+1) mod NUM_REQ.
  - rr_ptr changes only on a transfer.
  - A requester must hold its operands stable while req_valid & !req_ready. Dropping req_valid before transfer is allowed and is not flagged.
- S1 to S2: on s1_adv, S2 captures sum, cout, ovf and op_id, and sets rsp_valid=1.
  - ovf = (op_a[63] == b_eff[63]) & (sum[63] != op_a[63]), where b_eff = op_b ^ {64{op_sub}}.
- S1 clear: if s1_free and no transfer, op_valid clears.
- S2 clear: if rsp_valid & rsp_ready and !s1_adv, rsp_valid clears.
- Hold: rsp_* stay stable while rsp_valid & !rsp_ready.
- Latency: a request transferred in cycle T shows rsp_valid=1 with its result in cycle T+2, provided rsp_ready stayed high.
- Throughput: one result per cycle with continuous requests and rsp_ready=1.
- Back-pressure: with rsp_ready=0, S2 holds and S1 fills. Then s1_free=0 and all req_ready=0, so at most 2 transactions are in flight.
- Simultaneous events:
  - In one cycle, S2 may drain, S1 may move to S2, and a new request may load S1.
  - Nothing is lost or duplicated.
- Reset mid-operation: in-flight S1/S2 contents are discarded and no response is produced. After release, arbitration restarts at requester 0.
- Arithmetic wrap: 64-bit modulo. cout and ovf are reported and never saturated.

Test Plan:
- Add, single requester: req 0 sends a=0x0000_0000_0000_0003, b=0x5, sub=0 at T -> rsp at T+2: sum=0x8, cout=0, ovf=0, id=0.
- Subtract, both signs:
  - 5-7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - 7-5 -> sum=0x2, cout=1, ovf=0.
  - 0x7FFF_FFFF_FFFF_FFFF+1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- Round-robin: all four req_valid held with rsp_ready=1 -> grant order 0,1,2,3,0,1; rsp_id follows the same order, one response per cycle.
- Back-pressure: rsp_ready=0 for 5 cycles while all requesters are valid -> exactly 2 transfers. Then req_ready=0 and rsp_* hold stable. After rsp_ready=1, responses arrive in order with no loss or duplication.
- Skip idle requesters: only req 1 and req 3 valid, starting from rr_ptr=0 -> grants alternate 1,3,1,3.
- Async reset mid-flight: assert rst between clock edges while S1 and S2 are both full -> rsp_valid=0 and req_ready=0 immediately, with no clock needed. After release, a single req 2 transfers and returns id=2 two cycles later.
